// File: rtl/cp0_regs.sv
// cp0_regs: architectural CP0 register bank (BadVAddr, Count, Compare, Status, Cause, EPC).
// Applies MTC0 writes, exception entry and ERET, runs the Count timer and raises the timer
// interrupt. Snapshot packing on o_cp0_reg (MSB to LSB):
//   [191:160] BadVAddr, [159:128] Count, [127:96] Compare, [95:64] Status, [63:32] Cause,
//   [31:0] EPC.
module cp0_regs #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_WMASK = 32'h0000_FF03,
  parameter logic [31:0] CAUSE_WMASK  = 32'h0000_0300
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [7:0]   i_write_regsel,
  input  logic [31:0]  i_write_data,
  input  logic         i_exc_valid,
  input  logic [4:0]   i_exc_code,
  input  logic [31:0]  i_exc_pc,
  input  logic         i_exc_bd,
  input  logic         i_exc_bva_vld,
  input  logic [31:0]  i_exc_bva,
  input  logic         i_eret,
  input  logic [5:0]   i_ext_int,
  output logic [191:0] o_cp0_reg,
  output logic         o_int_pending,
  output logic         o_redirect,
  output logic [31:0]  o_redirect_pc
);

  // {rd, sel} encodings of the implemented registers
  localparam logic [7:0] SEL_BADVADDR = 8'h40;
  localparam logic [7:0] SEL_COUNT    = 8'h48;
  localparam logic [7:0] SEL_COMPARE  = 8'h58;
  localparam logic [7:0] SEL_STATUS   = 8'h60;
  localparam logic [7:0] SEL_CAUSE    = 8'h68;
  localparam logic [7:0] SEL_EPC      = 8'h70;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  // Field positions
  localparam int unsigned STATUS_IE  = 0;
  localparam int unsigned STATUS_EXL = 1;
  localparam int unsigned CAUSE_BD   = 31;
  localparam int unsigned CAUSE_TI   = 30;

  // Architectural state
  logic [31:0] r_badvaddr;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [31:0] r_status;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic        r_tick;
  logic        r_cmp_eq;

  // Next-state values
  logic [31:0] w_badvaddr_d;
  logic [31:0] w_count_d;
  logic [31:0] w_compare_d;
  logic [31:0] w_status_d;
  logic [31:0] w_cause_d;
  logic [31:0] w_epc_d;
  logic        w_tick_d;

  // Decoded MTC0 strobes
  logic        w_wr_allowed;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;

  logic        w_exl;
  logic        w_cmp_eq;
  logic        w_ti_set;

  assign w_exl = r_status[STATUS_EXL];

  // Decode MTC0 target; an exception in the same cycle drops every MTC0 write
  always_comb begin
    w_wr_allowed = ~i_exc_valid;
    w_wr_count   = w_wr_allowed && (i_write_regsel == SEL_COUNT);
    w_wr_compare = w_wr_allowed && (i_write_regsel == SEL_COMPARE);
    w_wr_status  = w_wr_allowed && (i_write_regsel == SEL_STATUS);
    w_wr_cause   = w_wr_allowed && (i_write_regsel == SEL_CAUSE);
    w_wr_epc     = w_wr_allowed && (i_write_regsel == SEL_EPC);
  end

  // Timer match; only a newly reached match sets TI, so the reset-time
  // Count == Compare == 0 does not raise a spurious timer interrupt
  always_comb begin
    w_cmp_eq = (r_count == r_compare);
    w_ti_set = w_cmp_eq & ~r_cmp_eq;
  end

  // BadVAddr: read-only to MTC0, loaded only by address-error exceptions
  always_comb begin
    w_badvaddr_d = r_badvaddr;
    if (i_exc_valid && i_exc_bva_vld) begin
      w_badvaddr_d = i_exc_bva;
    end
  end

  // Count: increments on every other cycle; MTC0 load restarts the half-rate phase
  always_comb begin
    w_tick_d  = ~r_tick;
    w_count_d = r_tick ? (r_count + 32'd1) : r_count;
    if (w_wr_count) begin
      w_tick_d  = 1'b0;
      w_count_d = i_write_data;
    end
  end

  // Compare: plain MTC0-writable register
  always_comb begin
    w_compare_d = r_compare;
    if (w_wr_compare) begin
      w_compare_d = i_write_data;
    end
  end

  // Status: masked MTC0 write, then EXL set by exception or cleared by ERET
  always_comb begin
    w_status_d = r_status;
    if (w_wr_status) begin
      w_status_d = (r_status & ~STATUS_WMASK) | (i_write_data & STATUS_WMASK);
    end
    if (i_exc_valid) begin
      w_status_d[STATUS_EXL] = 1'b1;
    end else if (i_eret) begin
      w_status_d[STATUS_EXL] = 1'b0;
    end
  end

  // Cause: software IP via MTC0, TI set/clear, hardware IP sampling, exception fields
  always_comb begin
    w_cause_d = r_cause;
    if (w_wr_cause) begin
      w_cause_d = (r_cause & ~CAUSE_WMASK) | (i_write_data & CAUSE_WMASK);
    end
    // Writing Compare acknowledges the timer and beats a same-cycle match
    if (w_wr_compare) begin
      w_cause_d[CAUSE_TI] = 1'b0;
    end else if (w_ti_set) begin
      w_cause_d[CAUSE_TI] = 1'b1;
    end
    w_cause_d[15:10] = {i_ext_int[5] | r_cause[CAUSE_TI], i_ext_int[4:0]};
    if (i_exc_valid) begin
      w_cause_d[6:2] = i_exc_code;
      if (!w_exl) begin
        w_cause_d[CAUSE_BD] = i_exc_bd;
      end
    end
  end

  // EPC: MTC0 write, overwritten by exception entry unless already at exception level
  always_comb begin
    w_epc_d = r_epc;
    if (w_wr_epc) begin
      w_epc_d = i_write_data;
    end
    if (i_exc_valid && !w_exl) begin
      w_epc_d = i_exc_bd ? (i_exc_pc - 32'd4) : i_exc_pc;
    end
  end

  // Register update; synchronous reset overrides everything in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_badvaddr <= 32'h0;
      r_count    <= 32'h0;
      r_compare  <= 32'h0;
      r_status   <= STATUS_RESET;
      r_cause    <= 32'h0;
      r_epc      <= 32'h0;
      r_tick     <= 1'b0;
      r_cmp_eq   <= 1'b1;
    end else begin
      r_badvaddr <= w_badvaddr_d;
      r_count    <= w_count_d;
      r_compare  <= w_compare_d;
      r_status   <= w_status_d;
      r_cause    <= w_cause_d;
      r_epc      <= w_epc_d;
      r_tick     <= w_tick_d;
      r_cmp_eq   <= w_cmp_eq;
    end
  end

  // Outputs: snapshot and interrupt from registered state, redirect from this cycle's commit
  always_comb begin
    o_cp0_reg     = {r_badvaddr, r_count, r_compare, r_status, r_cause, r_epc};
    o_int_pending = r_status[STATUS_IE] & ~r_status[STATUS_EXL] &
                    (|(r_cause[15:8] & r_status[15:8]));
    o_redirect    = i_exc_valid | i_eret;
    o_redirect_pc = i_exc_valid ? EXC_VECTOR : r_epc;
  end

endmodule
